// File: rtl/spi_reg_frontend.sv
// spi_reg_frontend: SPI write target holding the five PWM control registers.
// Optional SPI_READBACK_EN adds cipo readback of the addressed register on read frames.
module spi_reg_frontend #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES:0] sclk_q, ncs_q;
  logic [SYNC_STAGES-1:0] copi_q;
  logic [15:0] sr;
  logic [4:0] cnt;
  logic [7:0] regs [5];
  logic copi_s, sclk_rise, ncs_fall, ncs_rise, shift_en, hit, commit_wr, commit_err;
  // Chains reset low so a select already held low at reset release never looks like a fall
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sclk_q <= '0;
      ncs_q  <= '0;
      copi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-1:0], sclk};
      ncs_q  <= {ncs_q[SYNC_STAGES-1:0], ncs};
      copi_q <= {copi_q[SYNC_STAGES-2:0], copi};
    end
  assign copi_s     = copi_q[SYNC_STAGES-1];
  assign sclk_rise  = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
  assign ncs_fall   = ~ncs_q[SYNC_STAGES-1] & ncs_q[SYNC_STAGES];
  assign ncs_rise   = ncs_q[SYNC_STAGES-1] & ~ncs_q[SYNC_STAGES];
  assign shift_en   = (state == SHIFT) && sclk_rise && !ncs_rise;
  assign hit        = int'(sr[14:8]) <= MAX_ADDR;
  assign commit_wr  = (state == COMMIT) && (cnt == 5'd16) && sr[15] && hit;
  assign commit_err = (state == COMMIT) && ((cnt != 5'd16) || !hit);
  always_comb begin
    state_n = (state == IDLE && ncs_fall)   ? SHIFT  :
              (state == SHIFT && ncs_rise)  ? COMMIT :
              (state == COMMIT)             ? IDLE   : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr        <= '0;
      cnt       <= '0;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < 5; i++) regs[i] <= 8'h00;
    end else begin
      wr_strobe <= commit_wr;
      frame_err <= commit_err;
      if (state == IDLE && ncs_fall) begin
        sr  <= '0;
        cnt <= '0;
      end else if (shift_en) begin
        sr  <= {sr[14:0], copi_s};
        cnt <= (cnt == 5'd17) ? cnt : cnt + 5'd1;
      end
      for (int i = 0; i < 5; i++)
        if (commit_wr && sr[14:8] == 7'(i)) regs[i] <= sr[7:0];
    end
  assign en_reg_out_7_0  = regs[0];
  assign en_reg_out_15_8 = regs[1];
  assign en_reg_pwm_7_0  = regs[2];
  assign en_reg_pwm_15_8 = regs[3];
  assign pwm_duty_cycle  = regs[4];
`ifdef SPI_READBACK_EN
  logic [7:0] tx, rd_val;
  logic [6:0] rd_addr;
  logic tx_act, sclk_fall;
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
  assign rd_addr   = {sr[5:0], copi_s};
  always_comb begin
    rd_val = 8'h00;
    for (int i = 0; i < 5; i++)
      if (rd_addr == 7'(i) && i <= MAX_ADDR) rd_val = regs[i];
  end
  // Load at the 8th rise; the fall right after it must not shift, so bit 7 is held for the 9th rise
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx     <= '0;
      tx_act <= 1'b0;
    end else if (state != SHIFT) begin
      tx_act <= 1'b0;
    end else if (shift_en && cnt == 5'd7 && !sr[6]) begin
      tx     <= rd_val;
      tx_act <= 1'b1;
    end else if (sclk_fall && cnt >= 5'd9) begin
      tx <= {tx[6:0], 1'b0};
    end
  assign cipo = tx_act & tx[7] & ~ncs_q[SYNC_STAGES-1] & (state == SHIFT);
`else
  assign cipo = 1'b0;
`endif
endmodule

// File: tb/tb_spi_reg_frontend.sv
// tb_spi_reg_frontend: randomized and directed SPI frames checked against a register-map model.
module tb_spi_reg_frontend;
  localparam int S = 2;
  localparam int HALF = 6;
  logic clk = 1'b0, rst = 1'b0, sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
  logic cipo, wr_strobe, frame_err;
  logic [7:0] r0, r1, r2, r3, r4;
  logic [7:0] m [5];
  logic es = 1'b0, ee = 1'b0, in_frame = 1'b0;
  int tests = 0, fails = 0;

  spi_reg_frontend #(.SYNC_STAGES(S), .MAX_ADDR(4)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
    .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4),
    .wr_strobe(wr_strobe), .frame_err(frame_err));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    chk("reg0", r0, m[0]);
    chk("reg1", r1, m[1]);
    chk("reg2", r2, m[2]);
    chk("reg3", r3, m[3]);
    chk("reg4", r4, m[4]);
    chk("wr_strobe", wr_strobe, es);
    chk("frame_err", frame_err, ee);
`ifdef SPI_READBACK_EN
    if (!in_frame)
`endif
      chk("cipo_quiet", cipo, 0);
  end

  function automatic logic [7:0] peek(input logic [6:0] a);
    return (a <= 7'd4) ? m[a[2:0]] : 8'h00;
  endfunction

  task automatic frame(input logic [16:0] v, input int n, output logic [7:0] rx);
    logic [15:0] f;
    rx = 8'h00;
    in_frame = 1'b1;
    ncs = 1'b0;
    tick(HALF);
    for (int i = 0; i < n; i++) begin
      copi = v[n-1-i];
      tick(HALF);
      if (i >= 8 && i < 16) rx = {rx[6:0], cipo};
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
    tick(HALF);
    ncs = 1'b1;
    repeat (S + 2) @(posedge clk);
    f = v[15:0];
    if (n != 16 || f[14:8] > 7'd4) ee = 1'b1;
    else if (f[15]) begin
      m[f[10:8]] = f[7:0];
      es = 1'b1;
    end
    @(posedge clk);
    es = 1'b0;
    ee = 1'b0;
    #1 in_frame = 1'b0;
    tick(4);
  endtask

  task automatic wr(input logic [15:0] v);
    logic [7:0] rx;
    frame({1'b0, v}, 16, rx);
  endtask

  initial begin
    logic [7:0] rx, exp_rx;
    logic [16:0] v;
    int n;
    for (int i = 0; i < 5; i++) m[i] = 8'h00;
    rst = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(6);
    chk("reset_r4", r4, 8'h00);
    chk("reset_strobe", wr_strobe, 0);

    wr(16'h8455);
    chk("t2_duty", r4, 8'h55);
    chk("t2_r0", r0, 8'h00);
    wr(16'h80F0);
    wr(16'h83A5);
    chk("t3_r0", r0, 8'hF0);
    chk("t3_r3", r3, 8'hA5);
    wr(16'h8711);
    chk("t4_r0", r0, 8'hF0);
    frame({2'b0, 15'(16'h81AB >> 1)}, 15, rx);
    frame({16'h81AB, 1'b1}, 17, rx);
    chk("t5_r1", r1, 8'h00);

    wr(16'h8233);
    frame({1'b0, 16'h0200}, 16, rx);
`ifdef SPI_READBACK_EN
    chk("t6_readback", rx, 8'h33);
`else
    chk("t6_readback", rx, 8'h00);
`endif

    in_frame = 1'b1;
    ncs = 1'b0;
    tick(HALF);
    for (int i = 0; i < 6; i++) begin
      copi = 1'b1; tick(HALF); sclk = 1'b1; tick(HALF); sclk = 1'b0;
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) m[i] = 8'h00;
    tick(3);
    rst = 1'b0;
    tick(HALF);
    for (int i = 0; i < 10; i++) begin
      copi = 1'b1; tick(HALF); sclk = 1'b1; tick(HALF); sclk = 1'b0;
    end
    tick(HALF);
    ncs = 1'b1;
    tick(12);
    in_frame = 1'b0;
    chk("t1_r3_cleared", r3, 8'h00);
    wr(16'h8166);
    chk("t1_recover", r1, 8'h66);

    for (int k = 0; k < 110; k++) begin
      v = 17'($urandom);
      v[14:8] = 7'($urandom_range(0, 6));
      case ($urandom_range(0, 5))
        0: n = 15;
        1: n = 17;
        default: n = 16;
      endcase
      exp_rx = 8'h00;
`ifdef SPI_READBACK_EN
      exp_rx = peek(v[14:8]);
`endif
      frame(v, n, rx);
      if (n == 16 && !v[15]) chk("rand_readback", rx, exp_rx);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
